fetch_unit: RTL

//  Instruction fetch stage sitting directly upstream of the main control decoder.

---
 rtl/fetch_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the main control decoder.
// Owns the PC, issues one outstanding imem request at a time, holds the
// fetched word for the decoder and squashes stale fetches on redirect.
// Optional build macro: FETCH_MISALIGN_EN (adds fetch_misaligned output and
// halts fetch on a misaligned redirect target).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            stall,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode,
`ifdef FETCH_MISALIGN_EN
  output logic            fetch_misaligned,
`endif
  output logic [XLEN-1:0] pc_plus4
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] tgt;

`ifdef FETCH_MISALIGN_EN
  // Misaligned targets halt fetch, so the raw target is used as-is.
  assign tgt = branch_target;
`else
  assign tgt = {branch_target[XLEN-1:2], 2'b00};
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      kill_q     <= 1'b0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      kill_q     <= kill_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      mis_q      <= mis_d;
    end
  end

  // Next-state, PC update and redirect/squash handling.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    kill_d     = kill_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    mis_d      = mis_q;
    unique case (state_q)
      S_REQ: begin
        // Address stays on the bus until accepted; a redirect only retargets pc
        // and marks the in-flight fetch for squashing.
        if (imem_req_ready) state_d = S_WAIT;
        if (branch_taken) begin
          pc_d   = tgt;
          kill_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q || branch_taken) begin
            kill_d     = 1'b0;
            state_d    = S_REQ;
            pc_d       = branch_taken ? tgt : pc_q;
            req_addr_d = branch_taken ? tgt : pc_q;
          end else begin
            inst_d     = imem_rsp_data;
            inst_pc_d  = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = S_FULL;
          end
        end else if (branch_taken) begin
          kill_d = 1'b1;
          pc_d   = tgt;
        end
      end
      S_FULL: begin
        if (branch_taken) begin
          pc_d       = tgt;
          req_addr_d = tgt;
          state_d    = S_REQ;
        end else if (!stall) begin
          req_addr_d = pc_q;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_HALT;
    endcase
`ifdef FETCH_MISALIGN_EN
    if (branch_taken && (branch_target[1:0] != 2'b00)) begin
      mis_d   = 1'b1;
      state_d = S_HALT;
    end
`endif
  end

  assign imem_req_valid = rst_n && (state_q == S_REQ);
  assign imem_req_addr  = req_addr_q;
  assign inst_valid     = (state_q == S_FULL);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign opcode         = inst_q[6:0];
  assign pc_plus4       = inst_pc_q + 32'd4;
`ifdef FETCH_MISALIGN_EN
  assign fetch_misaligned = mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_q;
`endif

endmodule
